// File: rtl/bloom_pkg.sv
// Shared constants and types for the page-array blocks: array geometry,
// page-number type and the page-writer state encoding.
package bloom_pkg;

    localparam int unsigned ARR_SIZE  = 288;
    localparam int unsigned P_SIZE    = 12;
    localparam int unsigned NOP       = ARR_SIZE / P_SIZE;
    localparam int unsigned NOP_WIDTH = 5;
    localparam int unsigned B_SIZE    = 96;
    localparam int unsigned PPB       = B_SIZE / P_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    typedef logic [NOP_WIDTH-1:0] tpn_t;

endpackage

// File: rtl/tpn_slot_mux.sv
// Selects list entry idx from a packed page-number list.
// Ports:
//   list     packed entries, entry i at bits [NOP_WIDTH*i +: NOP_WIDTH]
//   idx      entry select
//   entry_c  selected entry (zero when idx >= NOP)
module tpn_slot_mux #(
    parameter int unsigned NOP       = bloom_pkg::NOP,
    parameter int unsigned NOP_WIDTH = bloom_pkg::NOP_WIDTH
) (
    input  logic [NOP_WIDTH*NOP-1:0] list,
    input  logic [NOP_WIDTH-1:0]     idx,
    output logic [NOP_WIDTH-1:0]     entry_c
);

    import bloom_pkg::*;

    always_comb begin
        entry_c = '0;
        for (int unsigned i = 0; i < NOP; i++) begin
            if (idx == NOP_WIDTH'(i)) begin
                entry_c = list[i*NOP_WIDTH +: NOP_WIDTH];
            end
        end
    end

endmodule

// File: rtl/tpn_page_writer.sv
// Writes a page signature into every page named in a packed page-number
// list, one list entry per cycle, building/rewriting a page array.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   start     begin a write pass (IDLE only; wins over clr)
//   clr       zero the whole array (IDLE only)
//   tpn_list  packed page numbers, entry i at [5i+4:5i]
//   tpn_cnt   number of valid entries (clamped to NOP)
//   sig       signature written into each listed page
//   arr       page array, page p at [12p+11:12p]
//   busy      high while entries are being written
//   done      one-cycle pulse at end of pass
//   err       sticky: out-of-range index or count seen in the last pass
module tpn_page_writer #(
    parameter int unsigned ARR_SIZE  = bloom_pkg::ARR_SIZE,
    parameter int unsigned P_SIZE    = bloom_pkg::P_SIZE,
    parameter int unsigned NOP       = bloom_pkg::NOP,
    parameter int unsigned NOP_WIDTH = bloom_pkg::NOP_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clr,
    input  logic [NOP_WIDTH*NOP-1:0] tpn_list,
    input  logic [NOP_WIDTH-1:0]     tpn_cnt,
    input  logic [P_SIZE-1:0]        sig,
    output logic [ARR_SIZE-1:0]      arr,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    import bloom_pkg::*;

    localparam int unsigned        LIST_W = NOP_WIDTH * NOP;
    localparam logic [NOP_WIDTH-1:0] NOP_T  = NOP_WIDTH'(NOP);

    wr_state_t              state_q;
    wr_state_t              state_d;
    logic [LIST_W-1:0]      list_q;
    logic [NOP_WIDTH-1:0]   cnt_q;
    logic [NOP_WIDTH-1:0]   idx_q;
    logic [P_SIZE-1:0]      sig_q;
    logic [NOP_WIDTH-1:0]   entry_c;
    logic                   load_c;
    logic                   clr_c;
    logic                   wr_c;
    logic                   bad_c;

    // Current list entry from the latched copy
    tpn_slot_mux #(
        .NOP       (NOP),
        .NOP_WIDTH (NOP_WIDTH)
    ) u_slot_mux (
        .list    (list_q),
        .idx     (idx_q),
        .entry_c (entry_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (idx_q == cnt_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        load_c = (state_q == IDLE) && start;
        clr_c  = (state_q == IDLE) && !start && clr;
        wr_c   = (state_q == WRITE) && (idx_q != cnt_q);
        bad_c  = wr_c && (entry_c >= NOP_T);
    end

    // Latched pass parameters, page array and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            list_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            sig_q  <= '0;
            arr    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            busy <= (state_d == WRITE);
            done <= (state_d == DONE);
            if (load_c) begin
                list_q <= tpn_list;
                cnt_q  <= (tpn_cnt > NOP_T) ? NOP_T : tpn_cnt;
                sig_q  <= sig;
                idx_q  <= '0;
                err    <= (tpn_cnt > NOP_T);
            end
            if (clr_c) begin
                arr <= '0;
            end
            if (wr_c) begin
                idx_q <= idx_q + 1'b1;
                if (bad_c) begin
                    err <= 1'b1;
                end
                // Out-of-range entries match no page and so write nothing
                for (int unsigned p = 0; p < NOP; p++) begin
                    if (entry_c == NOP_WIDTH'(p)) begin
                        arr[p*P_SIZE +: P_SIZE] <= sig_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tpn_page_writer.sv
// Scoreboard bench for tpn_page_writer: a page-array reference model
// predicts the array/err/done timing of each pass; a monitor checks them
// whenever done pulses.
module tb_tpn_page_writer;

    localparam int NP = 24;
    localparam int PW = 12;
    localparam int EW = 5;

    typedef struct {
        logic [NP*PW-1:0] arr;
        logic             err;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             clr = 1'b0;
    logic [NP*EW-1:0] tpn_list = '0;
    logic [EW-1:0]    tpn_cnt = '0;
    logic [PW-1:0]    sig = '0;
    logic [NP*PW-1:0] arr;
    logic             busy;
    logic             done;
    logic             err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [PW-1:0] model_pg [NP];
    logic          model_err;

    tpn_page_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clr      (clr),
        .tpn_list (tpn_list),
        .tpn_cnt  (tpn_cnt),
        .sig      (sig),
        .arr      (arr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NP*PW-1:0] pack(input logic [PW-1:0] pg [NP]);
        logic [NP*PW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*PW +: PW] = pg[p];
        return v;
    endfunction

    function automatic logic [NP*EW-1:0] put(input logic [NP*EW-1:0] l, input int i, input int v);
        l[i*EW +: EW] = EW'(v);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [NP*PW-1:0] act, input logic [NP*PW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) model_pg[p] = '0;
    endtask

    // Monitor: every done pulse consumes one predicted pass result
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done @cyc %0d: done=1 with no pass pending", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_arr", arr, mon_e.arr);
                chk("done_err", (NP*PW)'(err), (NP*PW)'(mon_e.err));
                chk("done_cycle", (NP*PW)'(cyc), (NP*PW)'(mon_e.cyc));
                chk("busy_during_done", (NP*PW)'(busy), '0);
            end
        end
    end

    // One write pass: predict, drive, follow the per-entry progress, wait for done
    task automatic run_pass(input logic [NP*EW-1:0] lst, input int cnt, input logic [PW-1:0] s,
                            input bit garble, input bit with_clr);
        logic [PW-1:0] run [NP];
        logic [PW-1:0] fin [NP];
        int   n, t, v, w;
        bit   e_err;
        exp_t e;
        n = (cnt > NP) ? NP : cnt;
        e_err = (cnt > NP);
        run = model_pg;
        fin = model_pg;
        for (int i = 0; i < n; i++) begin
            v = int'(lst[i*EW +: EW]);
            if (v < NP) fin[v] = s;
            else e_err = 1'b1;
        end
        @(negedge clk);
        start = 1'b1; clr = with_clr; tpn_list = lst; tpn_cnt = EW'(cnt); sig = s;
        t = cyc + 1;
        e.arr = pack(fin); e.err = e_err; e.cyc = t + 1 + n;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        chk("busy_on", (NP*PW)'(busy), (NP*PW)'(1));
        chk("arr_pass_start", arr, pack(run));
        for (int i = 0; i < n; i++) begin
            if (garble) begin
                start = 1'(($urandom & 32'd1)); clr = 1'(($urandom & 32'd1));
                tpn_list = {$urandom, $urandom, $urandom, $urandom};
                tpn_cnt = EW'($urandom); sig = PW'($urandom);
            end
            @(negedge clk);
            v = int'(lst[i*EW +: EW]);
            if (v < NP) run[v] = s;
            chk("arr_step", arr, pack(run));
        end
        start = 1'b0; clr = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (done !== 1'b1 && w < 8);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout @cyc %0d: done=%b required 1 within 8 cycles", cyc, done);
            exp_q.delete();
        end
        model_pg = fin;
        model_err = e_err;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk("arr_after_clr", arr, pack(model_pg));
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_arr"}, arr, pack(model_pg));
        chk({nm, "_busy"}, (NP*PW)'(busy), '0);
        chk({nm, "_done"}, (NP*PW)'(done), '0);
        chk({nm, "_err"}, (NP*PW)'(err), (NP*PW)'(model_err));
    endtask

    initial begin
        logic [NP*EW-1:0] l;
        logic [PW-1:0]    s;
        int               c;
        model_clear();
        model_err = 1'b0;

        // Reset, then idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");

        // Three distinct pages
        l = '0; l = put(l, 0, 2); l = put(l, 1, 9); l = put(l, 2, 23);
        run_pass(l, 3, 12'hA5C, 1'b0, 1'b0);

        // Empty list
        run_pass(l, 0, 12'h777, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("after_cnt0");

        // Out-of-range entry sets a sticky err
        l = '0; l = put(l, 0, 5); l = put(l, 1, 27); l = put(l, 2, 6);
        run_pass(l, 3, 12'h123, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_idle("err_sticky");
        l = '0; l = put(l, 0, 0); l = put(l, 1, 1);
        run_pass(l, 2, 12'hFFF, 1'b0, 1'b0);
        l = '0; l = put(l, 0, 1);
        run_pass(l, 1, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("two_pass");
        do_clr();

        // Count above NOP clamps and flags err; start wins over clr
        l = '0;
        for (int i = 0; i < NP; i++) l = put(l, i, NP - 1 - i);
        run_pass(l, 26, 12'h3C3, 1'b1, 1'b1);

        // Randomized passes with mid-pass input noise and idle clears
        for (int k = 0; k < 40; k++) begin
            l = '0;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 7) == 0) l = put(l, i, int'($urandom_range(NP, 31)));
                else l = put(l, i, int'($urandom_range(0, NP - 1)));
            end
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(0, NP));
            s = PW'($urandom);
            run_pass(l, c, s, 1'($urandom & 32'd1), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) do_clr();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset mid-pass: ignored start/clr pulses, then abort and clear
        l = '0;
        for (int i = 0; i < NP; i++) l = put(l, i, i);
        s = 12'h5A6;
        @(negedge clk);
        start = 1'b1; tpn_list = l; tpn_cnt = EW'(NP); sig = s;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            start = 1'(i % 2); clr = 1'((i + 1) % 2);
            @(negedge clk);
            model_pg[i] = s;
        end
        start = 1'b0; clr = 1'b0;
        chk("arr_before_abort", arr, pack(model_pg));
        chk("busy_before_abort", (NP*PW)'(busy), (NP*PW)'(1));
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        model_err = 1'b0;
        check_idle("abort");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("after_abort");

        l = '0; l = put(l, 0, 11);
        run_pass(l, 1, 12'hBEE, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_empty", (NP*PW)'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
